// File: rtl/pxs_vga_stream_gen.sv
// pxs_vga_stream_gen: source of the 23-bit VGA pixel stream.
// Free-running horizontal/vertical counters, advanced by the ce pixel enable,
// hold the coordinate of the next pixel. Every enabled edge registers that
// pixel's coordinates, sync levels, ActiveVideo and line/frame strobes.
// Stream layout: [22:13] X, [12:3] Y, [2] HSync, [1] VSync, [0] ActiveVideo.
// H_TOTAL and V_TOTAL must each be at most 1024.
module pxs_vga_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        ce,
  output logic [22:0] VGAStr_o,
  output logic        line_start_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter values before wrap.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds are 11 bits wide so a sync pulse ending exactly at 1024
  // still compares correctly against the zero-extended 10-bit counters.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Counters: coordinate of the next pixel to emit.
  logic [9:0] hcnt_reg;
  logic [9:0] vcnt_reg;
  logic [9:0] hcnt_next;
  logic [9:0] vcnt_next;

  // Registered stream fields.
  logic [9:0] x_reg;
  logic [9:0] y_reg;
  logic       hsync_reg;
  logic       vsync_reg;
  logic       active_reg;
  logic       line_start_reg;
  logic       frame_start_reg;

  // Decoded attributes of the pixel at (hcnt_reg, vcnt_reg).
  logic [10:0] hcnt_ext;
  logic [10:0] vcnt_ext;
  logic        active_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        line_start_next;
  logic        frame_start_next;

  assign hcnt_ext = {1'b0, hcnt_reg};
  assign vcnt_ext = {1'b0, vcnt_reg};

  // Next counter values: advance X, wrap at end of line and bump Y, wrap Y at end of frame.
  always_comb begin
    hcnt_next = hcnt_reg + 10'd1;
    vcnt_next = vcnt_reg;
    if (hcnt_reg == H_LAST) begin
      hcnt_next = 10'd0;
      if (vcnt_reg == V_LAST) begin
        vcnt_next = 10'd0;
      end else begin
        vcnt_next = vcnt_reg + 10'd1;
      end
    end
  end

  // Decode visibility, sync levels and strobes for the pixel about to be emitted.
  always_comb begin
    active_next      = (hcnt_ext < H_ACT_END) && (vcnt_ext < V_ACT_END);
    hsync_next       = ~SYNC_POL;
    vsync_next       = ~SYNC_POL;
    line_start_next  = (hcnt_reg == 10'd0);
    frame_start_next = (hcnt_reg == 10'd0) && (vcnt_reg == 10'd0);
    if ((hcnt_ext >= H_SYNC_BEG) && (hcnt_ext < H_SYNC_END)) begin
      hsync_next = SYNC_POL;
    end
    // VSync depends on the line only, so it changes together with Y at X=0.
    if ((vcnt_ext >= V_SYNC_BEG) && (vcnt_ext < V_SYNC_END)) begin
      vsync_next = SYNC_POL;
    end
  end

  // Counter state: advances only on enabled edges, cleared by reset.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hcnt_reg <= 10'd0;
      vcnt_reg <= 10'd0;
    end else if (ce) begin
      hcnt_reg <= hcnt_next;
      vcnt_reg <= vcnt_next;
    end
  end

  // Output register: captures the current pixel; holds (strobes stretch) while ce is low.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (ce) begin
      x_reg           <= hcnt_reg;
      y_reg           <= vcnt_reg;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      active_reg      <= active_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign VGAStr_o      = {x_reg, y_reg, hsync_reg, vsync_reg, active_reg};
  assign line_start_o  = line_start_reg;
  assign frame_start_o = frame_start_reg;

endmodule
